// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry and scheduler state type
package fb_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int NUM_PIXELS    = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int ADDR_WIDTH    = 19;

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_DRAW      = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } fb_sched_state_t;

endpackage

// File: rtl/fb_clear_counter.sv
// rtl/fb_clear_counter.sv - back-buffer clear address counter with restart and last flag
module fb_clear_counter #(
    parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
    parameter int NUM_PIXELS = fb_pkg::NUM_PIXELS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;

    assign addr_o = addr_q;
    assign last_o = (addr_q == LAST_ADDR);

    // Restart from zero on start; otherwise advance, wrapping after the last pixel
    always_comb begin
        addr_d = addr_q;
        if (start_i) begin
            addr_d = '0;
        end else if (step_i) begin
            addr_d = last_o ? '0 : addr_q + ADDR_WIDTH'(1);
        end
    end

    // Address register
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/fb_swap_scheduler.sv
// rtl/fb_swap_scheduler.sv - double-buffer clear/draw/swap scheduler; option FB_SCHED_SKIP_COUNT_EN adds skip_count
module fb_swap_scheduler #(
    parameter int   ADDR_WIDTH  = fb_pkg::ADDR_WIDTH,
    parameter int   NUM_PIXELS  = fb_pkg::NUM_PIXELS,
    parameter logic CLEAR_VALUE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_pulse,
    input  logic                  plot_valid,
    output logic                  plot_ready,
    input  logic [ADDR_WIDTH-1:0] plot_addr,
    input  logic                  plot_data,
    input  logic                  plot_frame_done,
    output logic                  fb0_wr_en,
    output logic                  fb1_wr_en,
    output logic [ADDR_WIDTH-1:0] fb_wr_addr,
    output logic                  fb_wr_data,
    output logic                  buffer_sel,
`ifdef FB_SCHED_SKIP_COUNT_EN
    output logic [15:0]           skip_count,
`endif
    output logic                  clearing,
    output logic                  frame_skip
);

    import fb_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

    fb_sched_state_t       state_q, state_d;
    logic                  buffer_sel_q, buffer_sel_d;
    logic                  fb0_wr_en_q, fb0_wr_en_d;
    logic                  fb1_wr_en_q, fb1_wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_data_q, wr_data_d;
    logic                  clearing_q, clearing_d;
    logic                  frame_skip_q, frame_skip_d;
    logic                  wr_en;
    logic                  swap;
    logic                  clr_start;
    logic                  clr_step;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_last;

    fb_clear_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_PIXELS (NUM_PIXELS)
    ) u_clear_counter (
        .clk     (clk),
        .reset   (reset),
        .start_i (clr_start),
        .step_i  (clr_step),
        .addr_o  (clr_addr),
        .last_o  (clr_last)
    );

    assign plot_ready = (state_q == ST_DRAW);
    assign fb0_wr_en  = fb0_wr_en_q;
    assign fb1_wr_en  = fb1_wr_en_q;
    assign fb_wr_addr = wr_addr_q;
    assign fb_wr_data = wr_data_q;
    assign buffer_sel = buffer_sel_q;
    assign clearing   = clearing_q;
    assign frame_skip = frame_skip_q;

    // Next state, write issue and swap decision; the back buffer is chosen from the current buffer_sel
    always_comb begin
        state_d      = state_q;
        buffer_sel_d = buffer_sel_q;
        wr_en        = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        clearing_d   = 1'b0;
        frame_skip_d = 1'b0;
        swap         = 1'b0;
        clr_step     = 1'b0;
        clr_start    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                wr_en      = 1'b1;
                wr_addr_d  = clr_addr;
                wr_data_d  = CLEAR_VALUE;
                clearing_d = 1'b1;
                clr_step   = 1'b1;
                if (clr_last) begin
                    state_d = ST_DRAW;
                end
                if (frame_pulse) begin
                    frame_skip_d = 1'b1;
                end
            end
            ST_DRAW: begin
                if (plot_valid && (plot_addr <= LAST_ADDR)) begin
                    wr_en     = 1'b1;
                    wr_addr_d = plot_addr;
                    wr_data_d = plot_data;
                end
                if (plot_frame_done && frame_pulse) begin
                    swap = 1'b1;
                end else if (plot_frame_done) begin
                    state_d = ST_WAIT_SWAP;
                end else if (frame_pulse) begin
                    frame_skip_d = 1'b1;
                end
            end
            ST_WAIT_SWAP: begin
                if (frame_pulse) begin
                    swap = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        if (swap) begin
            buffer_sel_d = ~buffer_sel_q;
            clr_start    = 1'b1;
            state_d      = ST_CLEAR;
        end
        fb0_wr_en_d = wr_en & buffer_sel_q;
        fb1_wr_en_d = wr_en & ~buffer_sel_q;
    end

    // State and registered write/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            buffer_sel_q <= 1'b0;
            fb0_wr_en_q  <= 1'b0;
            fb1_wr_en_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 1'b0;
            clearing_q   <= 1'b0;
            frame_skip_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buffer_sel_q <= buffer_sel_d;
            fb0_wr_en_q  <= fb0_wr_en_d;
            fb1_wr_en_q  <= fb1_wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            clearing_q   <= clearing_d;
            frame_skip_q <= frame_skip_d;
        end
    end

`ifdef FB_SCHED_SKIP_COUNT_EN
    logic [15:0] skip_count_q;

    assign skip_count = skip_count_q;

    // Saturating count of skipped frame pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            skip_count_q <= '0;
        end else if (frame_skip_d && (skip_count_q != 16'hFFFF)) begin
            skip_count_q <= skip_count_q + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fb_swap_scheduler.md
# fb_swap_scheduler

Double-buffer scheduler for the 1-bit VGA framebuffers in the 100 MHz domain. Owns `buffer_sel`, clears the back buffer after every swap, then grants the sample-to-pixel plotter exclusive write access, and swaps buffers only on a `frame_pulse` that arrives after both clear and plot are complete. Replaces the external clear/plot write-mux and per-buffer write-enable gating.

## Interface
Parameters:
- `ADDR_WIDTH`, 19, framebuffer address width.
- `NUM_PIXELS`, 307200, pixels per buffer (640×480).
- `CLEAR_VALUE`, 1'b0, pixel value written during clear.

Ports:
- `clk`  in  1  100 MHz system clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_pulse`  in  1  one-cycle start-of-frame pulse, already synchronous to `clk`.
- `plot_valid`  in  1  plotter write request.
- `plot_ready`  out  1  write accepted when `plot_valid && plot_ready`.
- `plot_addr`  in  ADDR_WIDTH  plotter pixel address.
- `plot_data`  in  1  plotter pixel value.
- `plot_frame_done`  in  1  one-cycle pulse: plotter finished this frame.
- `fb0_wr_en`, `fb1_wr_en`  out  1  per-buffer write enables.
- `fb_wr_addr`  out  ADDR_WIDTH  shared write address.
- `fb_wr_data`  out  1  shared write data.
- `buffer_sel`  out  1  displayed buffer (0 = fb0 displayed, writes go to fb1).
- `clearing`  out  1  high while in CLEAR.
- `frame_skip`  out  1  one-cycle pulse: `frame_pulse` arrived while not ready to swap.

## Operation
- States: CLEAR, DRAW, WAIT_SWAP.
- CLEAR: writes `CLEAR_VALUE` to back buffer, addresses 0..NUM_PIXELS-1, one per cycle; `plot_ready`=0. After address NUM_PIXELS-1 is issued → DRAW.
- DRAW: `plot_ready`=1; each handshake issues one write to the back buffer. `plot_addr >= NUM_PIXELS`: handshake completes, no write. `plot_frame_done` → WAIT_SWAP.
- WAIT_SWAP: `plot_ready`=0; `frame_pulse` → toggle `buffer_sel`, reset clear address, → CLEAR.
- `frame_pulse` in CLEAR or DRAW: no swap, `frame_skip` pulses, state unchanged.
- Simultaneous `plot_frame_done` and `frame_pulse` in DRAW: swap immediately (toggle, → CLEAR); no `frame_skip`.
- `plot_frame_done` in CLEAR or WAIT_SWAP: ignored.
- Back buffer = `!buffer_sel`: `fb1_wr_en` asserts only when `buffer_sel`=0, `fb0_wr_en` only when 1; never both.
- Reset mid-operation: all state abandoned, restart in CLEAR from address 0 with `buffer_sel`=0.

## Timing
- Reset values: `buffer_sel`=0, `fb0_wr_en`=`fb1_wr_en`=0, `fb_wr_addr`=0, `fb_wr_data`=0, `plot_ready`=0, `clearing`=0, `frame_skip`=0; state CLEAR, clear address 0.
- First clear write on the first cycle after `reset` deasserts; `clearing` rises the same cycle.
- Write outputs registered: handshake or clear step in cycle N → enable/addr/data valid in cycle N+1, one cycle wide.
- Back-buffer selection is taken from `buffer_sel` in cycle N, so a write accepted in the swap cycle lands in the old back buffer.
- Full clear: exactly NUM_PIXELS write cycles; `plot_ready` rises the cycle after the last clear write is issued.
- `buffer_sel` toggles in cycle N+1 after `frame_pulse` in cycle N (in WAIT_SWAP, or DRAW with a coincident done).
- `frame_skip` registered: cycle N+1.

## Configuration
- `FB_SCHED_SKIP_COUNT_EN`: when defined, adds output `skip_count` [15:0], a saturating count of `frame_skip` pulses. It resets to 0 and holds at 16'hFFFF. When undefined, the port and counter do not exist.

## Structure
- Package `fb_pkg`: `SCREEN_WIDTH`, `SCREEN_HEIGHT`, `NUM_PIXELS`, `ADDR_WIDTH`, and the state enum `fb_sched_state_t`.
- One sub-module, `fb_clear_counter`: address counter with start, step and a last flag; the top holds the FSM and output registers.

## Test plan
- Reset release, NUM_PIXELS=16 → 16 consecutive `fb1_wr_en` cycles, addr 0..15, data 0; `plot_ready`=1 next cycle.
- DRAW, plot handshake addr 5 data 1 → next cycle `fb1_wr_en`=1, `fb_wr_addr`=5, `fb_wr_data`=1, `fb0_wr_en`=0.
- `plot_frame_done`, then `frame_pulse` → `buffer_sel`=1, CLEAR restarts on fb0 with 16 writes.
- `frame_pulse` during CLEAR → `frame_skip` pulse, `buffer_sel` unchanged, clear completes; with macro, `skip_count`=1.
- Plot addr 16 (NUM_PIXELS=16) → handshake completes, no write enable asserted.
- `reset` asserted mid-DRAW with `buffer_sel`=1 → `buffer_sel`=0, clear restarts from addr 0 on fb1.
